// File: rtl/chimera_dbg_responder.sv
// UART-side debug preload responder: parses WRITE/READ/EXIT byte commands,
// performs single-word OBI accesses and streams the response bytes back.
module chimera_dbg_responder #(
  parameter int unsigned TimeoutCycles = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  input  logic        eoc_valid_i,
  input  logic [31:0] eoc_code_i,
  output logic        eoc_seen_o,
  output logic        busy_o
);
  localparam int TW = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM_REQ, MEM_RESP, TX} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q, eoc_code_q;
  logic          eoc_seen_q;
  logic [39:0]   tx_buf_q;
  logic [2:0]    tx_left_q;
  logic [TW-1:0] tmo_q;

  logic          rx_fire, tx_fire, tmo_hit, in_payload;
  logic [31:0]   addr_nxt, exit_code;
  logic          exit_stat;
  logic          ld_tx;
  logic [39:0]   ld_buf;
  logic [2:0]    ld_last;

  assign in_payload  = (state_q == ADDR) || (state_q == DATA);
  assign rx_ready_o  = !rst_i && ((state_q == IDLE) || in_payload);
  assign rx_fire     = rx_valid_i && rx_ready_o;
  assign tx_valid_o  = (state_q == TX);
  assign tx_fire     = tx_valid_o && tx_ready_i;
  assign tx_data_o   = tx_buf_q[7:0];
  assign mem_req_o   = (state_q == MEM_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = 4'hF;
  assign eoc_seen_o  = eoc_seen_q;
  assign busy_o      = (state_q != IDLE);

  // Address arrives little-endian, so each byte shifts in from the top.
  assign addr_nxt = {rx_data_i, addr_q[31:8]};
  assign tmo_hit  = in_payload && !rx_fire && (tmo_q == TW'(TimeoutCycles - 1));

  // A pulse coincident with the EXIT opcode must already be visible in its reply.
  assign exit_stat = eoc_seen_q || eoc_valid_i;
  assign exit_code = eoc_seen_q ? eoc_code_q : (eoc_valid_i ? eoc_code_i : 32'h0);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_tx   = 1'b0;
    ld_buf  = {32'h0, 8'hEE};
    ld_last = 3'd0;
    case (state_q)
      IDLE: if (rx_fire) begin
        case (rx_data_i)
          8'h01, 8'h02: state_d = ADDR;
          8'h03: begin
            state_d = TX;
            ld_tx   = 1'b1;
            ld_buf  = {exit_code, 7'h0, exit_stat};
            ld_last = 3'd4;
          end
          default: begin
            state_d = TX;
            ld_tx   = 1'b1;
          end
        endcase
      end
      ADDR: begin
        if (tmo_hit) begin
          state_d = TX;
          ld_tx   = 1'b1;
        end else if (rx_fire && cnt_q == 2'd3) begin
          if (we_q) state_d = DATA;
          else if (addr_nxt[1:0] != 2'b00) begin
            state_d = TX;
            ld_tx   = 1'b1;
          end else state_d = MEM_REQ;
        end
      end
      DATA: begin
        if (tmo_hit) begin
          state_d = TX;
          ld_tx   = 1'b1;
        end else if (rx_fire && cnt_q == 2'd3) begin
          if (addr_q[1:0] != 2'b00) begin
            state_d = TX;
            ld_tx   = 1'b1;
          end else state_d = MEM_REQ;
        end
      end
      MEM_REQ: if (mem_gnt_i) state_d = MEM_RESP;
      MEM_RESP: if (mem_rvalid_i) begin
        state_d = TX;
        ld_tx   = 1'b1;
        if (mem_err_i)  ld_buf = {32'h0, 8'hEE};
        else if (we_q)  ld_buf = {32'h0, 8'h5A};
        else begin
          ld_buf  = {8'h0, mem_rdata_i};
          ld_last = 3'd3;
        end
      end
      TX: if (tx_fire && tx_left_q == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= 2'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      eoc_code_q <= 32'h0;
      eoc_seen_q <= 1'b0;
      tx_buf_q   <= 40'h0;
      tx_left_q  <= 3'd0;
      tmo_q      <= '0;
    end else begin
      if (eoc_valid_i && !eoc_seen_q) begin
        eoc_seen_q <= 1'b1;
        eoc_code_q <= eoc_code_i;
      end
      if (in_payload) tmo_q <= rx_fire ? '0 : tmo_q + TW'(1);
      else            tmo_q <= '0;
      if (rx_fire) begin
        case (state_q)
          IDLE: begin
            we_q  <= (rx_data_i == 8'h01);
            cnt_q <= 2'd0;
          end
          ADDR: begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q + 2'd1;
          end
          DATA: begin
            wdata_q <= {rx_data_i, wdata_q[31:8]};
            cnt_q   <= cnt_q + 2'd1;
          end
          default: ;
        endcase
      end
      if (ld_tx) begin
        tx_buf_q  <= ld_buf;
        tx_left_q <= ld_last;
      end else if (tx_fire) begin
        tx_buf_q  <= {8'h0, tx_buf_q[39:8]};
        tx_left_q <= tx_left_q - 3'd1;
      end
    end
  end
endmodule
